// File: rtl/riscv_trace_pkg.sv
// Shared definitions for the retirement-trace recorder: FSM state encoding and
// the width of one stored trace entry.
package riscv_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    // One entry packs {timestamp, PC, WE, RD, WD}.
    function automatic int entry_w(input int cw, input int dw, input int aw);
        return cw + 2 * dw + aw + 1;
    endfunction

endpackage

// File: rtl/riscv_trace_buf_if.sv
// Control, retire-tap and drain signals of the trace recorder. The master is the
// core/debug host side; the slave is the recorder itself.
interface riscv_trace_buf_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int CWIDTH = 16,
    parameter int CNTW   = 5
);
    logic              ARM;
    logic              STOP;
    logic              TRIG_EN;
    logic [DWIDTH-1:0] TRIG_PC;
    logic              TR_VALID;
    logic [DWIDTH-1:0] TR_PC;
    logic              TR_WE;
    logic [AWIDTH-1:0] TR_RD;
    logic [DWIDTH-1:0] TR_WD;
    logic              POP;
    logic              OUT_VALID;
    logic [CWIDTH-1:0] OUT_TS;
    logic [DWIDTH-1:0] OUT_PC;
    logic              OUT_WE;
    logic [AWIDTH-1:0] OUT_RD;
    logic [DWIDTH-1:0] OUT_WD;
    logic [CNTW-1:0]   COUNT;
    logic              OVF;
    logic [1:0]        STATE;

    modport master (
        output ARM, STOP, TRIG_EN, TRIG_PC, TR_VALID, TR_PC, TR_WE, TR_RD, TR_WD, POP,
        input  OUT_VALID, OUT_TS, OUT_PC, OUT_WE, OUT_RD, OUT_WD, COUNT, OVF, STATE
    );

    modport slave (
        input  ARM, STOP, TRIG_EN, TRIG_PC, TR_VALID, TR_PC, TR_WE, TR_RD, TR_WD, POP,
        output OUT_VALID, OUT_TS, OUT_PC, OUT_WE, OUT_RD, OUT_WD, COUNT, OVF, STATE
    );

endinterface

// File: rtl/riscv_trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the occupancy count.
module riscv_trace_ram #(
    parameter int DEPTH = 16,
    parameter int EW    = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [EW-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [EW-1:0] rdata_o
);

    logic [EW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscv_trace_buf.sv
// Retirement-trace recorder: after a PC trigger, records timestamped MEM/WB
// writebacks into a ring drained through a first-word-fall-through pop port.
module riscv_trace_buf
    import riscv_trace_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 16,
    parameter int CWIDTH = 16,
    parameter int WRAP   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    riscv_trace_buf_if.slave bus
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int EW   = entry_w(CWIDTH, DWIDTH, AWIDTH);

    trace_state_e      state_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CNTW-1:0]   count_q;
    logic [CNTW-1:0]   count_d;
    logic              ovf_q;
    logic [CWIDTH-1:0] ts_q;

    logic full;
    logic trig_hit;
    logic push_req;
    logic push;
    logic pop;
    logic overwrite;

    logic [EW-1:0]     wdata;
    logic [EW-1:0]     rdata;
    logic [CWIDTH-1:0] rd_ts;
    logic [DWIDTH-1:0] rd_pc;
    logic              rd_we;
    logic [AWIDTH-1:0] rd_rd;
    logic [DWIDTH-1:0] rd_wd;

    // ARM outranks STOP, which outranks capture: neither cycle records a retire.
    always_comb begin
        full      = (count_q == CNTW'(DEPTH));
        trig_hit  = bus.TR_VALID && (!bus.TRIG_EN || (bus.TR_PC == bus.TRIG_PC));
        push_req  = !bus.ARM && !bus.STOP &&
                    (((state_q == ST_CAPTURE) && bus.TR_VALID) ||
                     ((state_q == ST_WAIT) && trig_hit));
        pop       = !bus.ARM && bus.POP && (count_q != '0);
        push      = push_req && !((WRAP == 0) && full && !pop);
        overwrite = push && full && !pop;

        count_d = count_q;
        if (push && !pop && !full) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ts_q     <= '0;
        end else if (bus.ARM) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ts_q     <= '0;
        end else begin
            ts_q    <= ts_q + CWIDTH'(1);
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop || overwrite) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (overwrite) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else if (bus.ARM) begin
            state_q <= ST_WAIT;
        end else if (bus.STOP) begin
            state_q <= ST_DONE;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (trig_hit) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if ((WRAP == 0) && push && (count_d == CNTW'(DEPTH))) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign wdata = {ts_q, bus.TR_PC, bus.TR_WE, bus.TR_RD, bus.TR_WD};

    riscv_trace_ram #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_ram (
        .clk     (CLK),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign {rd_ts, rd_pc, rd_we, rd_rd, rd_wd} = rdata;

    // Storage is unreset, so fields are gated to zero while the ring is empty.
    assign bus.OUT_VALID = (count_q != '0);
    assign bus.OUT_TS    = bus.OUT_VALID ? rd_ts : '0;
    assign bus.OUT_PC    = bus.OUT_VALID ? rd_pc : '0;
    assign bus.OUT_WE    = bus.OUT_VALID ? rd_we : 1'b0;
    assign bus.OUT_RD    = bus.OUT_VALID ? rd_rd : '0;
    assign bus.OUT_WD    = bus.OUT_VALID ? rd_wd : '0;
    assign bus.COUNT     = count_q;
    assign bus.OVF       = ovf_q;
    assign bus.STATE     = state_q;

endmodule

// File: tb/tb_riscv_trace_buf.sv
// Directed bench for riscv_trace_buf: a stop-when-full and an overwrite instance
// are driven with identical stimulus and checked against hand-computed values.
module tb_riscv_trace_buf;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int NW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic          trig_en = 1'b0;
    logic [DW-1:0] trig_pc = '0;
    logic          tr_valid = 1'b0;
    logic [DW-1:0] tr_pc = '0;
    logic          tr_we = 1'b0;
    logic [AW-1:0] tr_rd = '0;
    logic [DW-1:0] tr_wd = '0;
    logic          pop = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_trace_buf_if #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW), .CNTW(NW)) if_a ();
    riscv_trace_buf_if #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW), .CNTW(NW)) if_b ();

    assign if_a.ARM = arm;           assign if_b.ARM = arm;
    assign if_a.STOP = stop;         assign if_b.STOP = stop;
    assign if_a.TRIG_EN = trig_en;   assign if_b.TRIG_EN = trig_en;
    assign if_a.TRIG_PC = trig_pc;   assign if_b.TRIG_PC = trig_pc;
    assign if_a.TR_VALID = tr_valid; assign if_b.TR_VALID = tr_valid;
    assign if_a.TR_PC = tr_pc;       assign if_b.TR_PC = tr_pc;
    assign if_a.TR_WE = tr_we;       assign if_b.TR_WE = tr_we;
    assign if_a.TR_RD = tr_rd;       assign if_b.TR_RD = tr_rd;
    assign if_a.TR_WD = tr_wd;       assign if_b.TR_WD = tr_wd;
    assign if_a.POP = pop;           assign if_b.POP = pop;

    riscv_trace_buf #(
        .DWIDTH(DW), .AWIDTH(AW), .DEPTH(16), .CWIDTH(CW), .WRAP(0)
    ) u_a (
        .CLK (clk),
        .RST (rst),
        .bus (if_a)
    );

    riscv_trace_buf #(
        .DWIDTH(DW), .AWIDTH(AW), .DEPTH(16), .CWIDTH(CW), .WRAP(1)
    ) u_b (
        .CLK (clk),
        .RST (rst),
        .bus (if_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [DW-1:0] pc);
        tr_valid = 1'b1;
        tr_pc    = pc;
        tr_we    = 1'b1;
        tr_rd    = pc[6:2];
        tr_wd    = ~pc;
        tick();
        tr_valid = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles
        repeat (3) tick();
        chk("rst_state", 64'(if_a.STATE), 64'(0));
        chk("rst_count", 64'(if_a.COUNT), 64'(0));
        chk("rst_ovf", 64'(if_a.OVF), 64'(0));
        chk("rst_valid", 64'(if_a.OUT_VALID), 64'(0));
        chk("rst_pc", 64'(if_a.OUT_PC), 64'(0));
        rst = 1'b0;

        retire(32'h40);
        retire(32'h44);
        chk("prearm_count", 64'(if_a.COUNT), 64'(0));
        chk("prearm_state", 64'(if_a.STATE), 64'(0));

        // PC trigger at 0x10
        trig_en = 1'b1;
        trig_pc = 32'h10;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_state", 64'(if_a.STATE), 64'(1));
        for (int i = 0; i < 4; i++) retire(32'(4 * i));
        chk("pretrig_state", 64'(if_a.STATE), 64'(1));
        chk("pretrig_count", 64'(if_a.COUNT), 64'(0));
        retire(32'h10);
        chk("trig_state", 64'(if_a.STATE), 64'(2));
        chk("trig_count", 64'(if_a.COUNT), 64'(1));
        chk("trig_fwft_pc", 64'(if_a.OUT_PC), 64'(32'h10));
        retire(32'h14);
        retire(32'h18);
        retire(32'h1C);
        chk("trig4_count", 64'(if_a.COUNT), 64'(4));
        chk("trig4_pc", 64'(if_a.OUT_PC), 64'(32'h10));
        chk("trig4_ts", 64'(if_a.OUT_TS), 64'(4));
        chk("trig4_rd", 64'(if_a.OUT_RD), 64'(4));
        chk("trig4_wd", 64'(if_a.OUT_WD), 64'(32'hFFFF_FFEF));
        chk("trig4_we", 64'(if_a.OUT_WE), 64'(1));
        chk("trig4_b_count", 64'(if_b.COUNT), 64'(4));

        // ARM + STOP + matching retire in one cycle: ARM wins, retire dropped
        arm = 1'b1;
        stop = 1'b1;
        tr_valid = 1'b1;
        tr_pc = 32'h10;
        tick();
        arm = 1'b0;
        stop = 1'b0;
        tr_valid = 1'b0;
        chk("armstop_state", 64'(if_a.STATE), 64'(1));
        chk("armstop_count", 64'(if_a.COUNT), 64'(0));
        chk("armstop_valid", 64'(if_a.OUT_VALID), 64'(0));
        retire(32'h10);
        chk("rearm_ts", 64'(if_a.OUT_TS), 64'(0));
        chk("rearm_count", 64'(if_a.COUNT), 64'(1));
        chk("rearm_state", 64'(if_a.STATE), 64'(2));

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_state", 64'(if_a.STATE), 64'(3));
        pop = 1'b1;
        tick();
        chk("pop_last_count", 64'(if_a.COUNT), 64'(0));
        tick();
        pop = 1'b0;
        chk("pop_empty_count", 64'(if_a.COUNT), 64'(0));
        chk("pop_empty_valid", 64'(if_a.OUT_VALID), 64'(0));
        chk("pop_empty_state", 64'(if_a.STATE), 64'(3));

        // Immediate start, 20 retires: A stops full, B overwrites the oldest four
        trig_en = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm2_ovf", 64'(if_b.OVF), 64'(0));
        for (int i = 0; i < 20; i++) retire(32'h100 + 32'(4 * i));
        chk("a20_state", 64'(if_a.STATE), 64'(3));
        chk("a20_count", 64'(if_a.COUNT), 64'(16));
        chk("a20_ovf", 64'(if_a.OVF), 64'(0));
        chk("a20_pc", 64'(if_a.OUT_PC), 64'(32'h100));
        chk("a20_ts", 64'(if_a.OUT_TS), 64'(0));
        chk("b20_state", 64'(if_b.STATE), 64'(2));
        chk("b20_count", 64'(if_b.COUNT), 64'(16));
        chk("b20_ovf", 64'(if_b.OVF), 64'(1));
        chk("b20_pc", 64'(if_b.OUT_PC), 64'(32'h110));
        chk("b20_ts", 64'(if_b.OUT_TS), 64'(4));

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("b20_stop_state", 64'(if_b.STATE), 64'(3));
        for (int i = 0; i < 16; i++) begin
            chk("a_drain_pc", 64'(if_a.OUT_PC), 64'(32'h100 + 32'(4 * i)));
            chk("b_drain_pc", 64'(if_b.OUT_PC), 64'(32'h110 + 32'(4 * i)));
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        chk("a_drained_valid", 64'(if_a.OUT_VALID), 64'(0));
        chk("b_drained_valid", 64'(if_b.OUT_VALID), 64'(0));
        chk("b_drained_count", 64'(if_b.COUNT), 64'(0));

        // Full ring, simultaneous push and pop
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 16; i++) retire(32'h300 + 32'(4 * i));
        chk("b16_count", 64'(if_b.COUNT), 64'(16));
        chk("b16_ovf", 64'(if_b.OVF), 64'(0));
        chk("a16_state", 64'(if_a.STATE), 64'(3));
        tr_valid = 1'b1;
        tr_pc = 32'h400;
        pop = 1'b1;
        tick();
        tr_valid = 1'b0;
        pop = 1'b0;
        chk("pushpop_b_count", 64'(if_b.COUNT), 64'(16));
        chk("pushpop_b_ovf", 64'(if_b.OVF), 64'(0));
        chk("pushpop_b_pc", 64'(if_b.OUT_PC), 64'(32'h304));
        chk("pushpop_a_count", 64'(if_a.COUNT), 64'(15));
        chk("pushpop_a_pc", 64'(if_a.OUT_PC), 64'(32'h304));
        retire(32'h404);
        chk("ovw_b_ovf", 64'(if_b.OVF), 64'(1));
        chk("ovw_b_count", 64'(if_b.COUNT), 64'(16));
        chk("ovw_b_pc", 64'(if_b.OUT_PC), 64'(32'h308));

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_state", 64'(if_b.STATE), 64'(0));
        chk("async_count", 64'(if_b.COUNT), 64'(0));
        chk("async_ovf", 64'(if_b.OVF), 64'(0));
        chk("async_valid", 64'(if_b.OUT_VALID), 64'(0));
        tick();
        rst = 1'b0;
        retire(32'h500);
        chk("post_rst_count", 64'(if_b.COUNT), 64'(0));
        chk("post_rst_state", 64'(if_b.STATE), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
